// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared CDB definitions: default bus geometry, functional-unit channel indices
// and the index-width helper used by the arbiter and its picker.
package cdb_rr_arbiter_pkg;

  localparam int CDB_NUM_CH = 5;
  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  typedef enum int unsigned {
    CH_ADD   = 0,
    CH_LOGIC = 1,
    CH_MUL   = 2,
    CH_LOAD  = 3,
    CH_STORE = 4
  } cdb_ch_e;

  // Width of a channel index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// Combinational request picker: round-robin after ptr when mode=1,
// lowest index first when mode=0. Returns one-hot grant, index and any.
module cdb_rr_arbiter_rr_pick
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH = CDB_NUM_CH,
  localparam int IW    = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx,
  output logic              any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Modulo scan keeps the wrap correct for non-power-of-two channel counts.
    for (int k = 0; k < NUM_CH; k++) begin
      cand = mode ? IW'((int'(ptr) + 1 + k) % NUM_CH) : IW'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional-unit channel, one
// registered {tag,val} broadcast per cycle, flush discards all held results.
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int              NUM_CH      = CDB_NUM_CH,
  parameter int              TAG_W       = CDB_TAG_W,
  parameter int              DATA_W      = CDB_DATA_W,
  parameter logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}},
  parameter int              RR_MODE     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_flush,
  input  logic [NUM_CH-1:0]          in_request,
  input  logic [NUM_CH*TAG_W-1:0]    in_tag,
  input  logic [NUM_CH*DATA_W-1:0]   in_val,
  output logic [NUM_CH-1:0]          out_ready,
  output logic                       out_broadcast,
  output logic [TAG_W-1:0]           out_tag,
  output logic [DATA_W-1:0]          out_val,
  output logic [idx_w(NUM_CH)-1:0]   out_grant_ch
);

  localparam int IW = idx_w(NUM_CH);

  logic [NUM_CH-1:0] slot_vld_p0;
  logic [TAG_W-1:0]  slot_tag_p0 [NUM_CH];
  logic [DATA_W-1:0] slot_val_p0 [NUM_CH];
  logic [IW-1:0]     rr_ptr;

  logic [NUM_CH-1:0] pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [NUM_CH-1:0] grant;
  logic              grant_any;
  logic [NUM_CH-1:0] capture;

  cdb_rr_arbiter_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (slot_vld_p0),
    .ptr   (rr_ptr),
    .mode  (RR_MODE != 0),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A flush cycle issues no grant, so nothing leaves the slots on that edge.
  assign grant     = in_flush ? '0 : pick_grant;
  assign grant_any = pick_any & ~in_flush;
  assign out_ready = rst ? '0 : (~slot_vld_p0 | grant);
  assign capture   = in_flush ? '0 : (in_request & out_ready);

  // Stage p0: per-channel holding slots (data path, no reset needed)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (capture[i]) begin
        slot_tag_p0[i] <= in_tag[i*TAG_W +: TAG_W];
        slot_val_p0[i] <= in_val[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p0 -> bus: slot occupancy, pointer and registered broadcast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_p0   <= '0;
      rr_ptr        <= IW'(NUM_CH - 1);
      out_broadcast <= 1'b0;
      out_tag       <= INVALID_TAG;
      out_val       <= '0;
      out_grant_ch  <= '0;
    end else begin
      if (in_flush) slot_vld_p0 <= '0;
      else          slot_vld_p0 <= capture | (slot_vld_p0 & ~grant);
      out_broadcast <= grant_any;
      if (grant_any) begin
        out_tag      <= slot_tag_p0[pick_idx];
        out_val      <= slot_val_p0[pick_idx];
        out_grant_ch <= pick_idx;
        rr_ptr       <= pick_idx;
      end else begin
        out_tag <= INVALID_TAG;
        out_val <= '0;
      end
    end
  end

endmodule
